// File: rtl/readout_aggregator.sv
// Round-robin readout aggregator: pops 32-bit words from CHANNELS FWFT sources,
// buffers them, and serializes each word little-endian onto an 8-bit stream.
module readout_aggregator #(
   parameter int CHANNELS    = 4,
   parameter int DEPTH       = 1024,
   parameter int TAG_CHANNEL = 0
) (
   input  logic                     BUS_CLK,
   input  logic                     BUS_RST,
   input  logic [CHANNELS-1:0]      FIFO_EMPTY,
   input  logic [32*CHANNELS-1:0]   FIFO_DATA,
   output logic [CHANNELS-1:0]      FIFO_READ,
   input  logic                     TX_AFULL,
   output logic                     TX_WR,
   output logic [7:0]               TX_DATA,
   output logic [$clog2(DEPTH):0]   FILL_LEVEL
);

   localparam int IDW = $clog2(CHANNELS);
   localparam int AW  = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [IDW-1:0] last_q;
   logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [AW:0]    fill_q, fill_d;
   logic [31:0]    mem_q [DEPTH];
   logic [31:0]    ser_q;
   logic [1:0]     idx_q;
   logic           ser_vld_q;

   logic           grant;
   logic [IDW-1:0] gidx;
   logic [IDW-1:0] cidx;
   logic [31:0]    gword;
   logic           tx_wr;
   logic           ser_load;

   // Search starts one past the last grant, so a busy channel cannot starve others.
   always_comb begin
      grant = 1'b0;
      gidx  = last_q;
      cidx  = '0;
      for (int k = 1; k <= CHANNELS; k++) begin
         cidx = IDW'((int'(last_q) + k) % CHANNELS);
         if (!grant && !FIFO_EMPTY[cidx]) begin
            grant = 1'b1;
            gidx  = cidx;
         end
      end
      if (BUS_RST || fill_q == FULL) grant = 1'b0;
   end

   always_comb begin
      FIFO_READ = '0;
      if (grant) FIFO_READ[gidx] = 1'b1;
   end

   always_comb begin
      gword = FIFO_DATA[32*int'(gidx) +: 32];
      if (TAG_CHANNEL != 0) gword[31 -: IDW] = gidx;
   end

   assign tx_wr    = ser_vld_q && !TX_AFULL && !BUS_RST;
   // Reloading on the last byte keeps the byte stream gapless across words.
   assign ser_load = (fill_q != '0) && (!ser_vld_q || (idx_q == 2'd3 && tx_wr));

   always_comb begin
      fill_d = fill_q;
      if (grant && !ser_load)      fill_d = fill_q + 1'b1;
      else if (!grant && ser_load) fill_d = fill_q - 1'b1;
   end

   always_ff @(posedge BUS_CLK) begin
      if (grant) mem_q[wr_ptr_q] <= gword;
   end

   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST) begin
         last_q    <= IDW'(CHANNELS-1);
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         fill_q    <= '0;
         ser_q     <= '0;
         idx_q     <= '0;
         ser_vld_q <= 1'b0;
      end else begin
         if (grant) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            last_q   <= gidx;
         end
         if (ser_load) begin
            rd_ptr_q  <= rd_ptr_q + 1'b1;
            ser_q     <= mem_q[rd_ptr_q];
            ser_vld_q <= 1'b1;
            idx_q     <= '0;
         end else if (tx_wr) begin
            idx_q <= idx_q + 1'b1;
            if (idx_q == 2'd3) ser_vld_q <= 1'b0;
         end
         fill_q <= fill_d;
      end
   end

   assign TX_WR      = tx_wr;
   assign TX_DATA    = (ser_vld_q && !BUS_RST) ? ser_q[8*idx_q +: 8] : 8'h00;
   assign FILL_LEVEL = BUS_RST ? '0 : fill_q;

endmodule

// File: tb/tb_readout_aggregator.sv
// Directed bench for readout_aggregator: plain and tagged instances share one source model.
module tb_readout_aggregator;
   localparam int CH  = 4;
   localparam int DEP = 16;

   logic clk = 1'b0, rst = 1'b1, afull = 1'b0;
   logic [CH-1:0]    fifo_empty, fifo_read, fifo_read_t;
   logic [32*CH-1:0] fifo_data;
   logic             tx_wr, tx_wr_t;
   logic [7:0]       tx_data, tx_data_t;
   logic [4:0]       fill, fill_t;

   int n_cmp = 0, n_err = 0;
   int head[CH] = '{default: 0};
   int cnt[CH]  = '{default: 0};
   logic [31:0] sd[CH][256];
   int cyc = 0;
   logic [7:0] rx_d[2048];
   int rx_t[2048];
   int rx_n = 0;
   int gl[512];
   int gn = 0;

   readout_aggregator #(.CHANNELS(CH), .DEPTH(DEP), .TAG_CHANNEL(0)) u_dut (
      .BUS_CLK(clk), .BUS_RST(rst), .FIFO_EMPTY(fifo_empty), .FIFO_DATA(fifo_data),
      .FIFO_READ(fifo_read), .TX_AFULL(afull), .TX_WR(tx_wr), .TX_DATA(tx_data),
      .FILL_LEVEL(fill));

   readout_aggregator #(.CHANNELS(CH), .DEPTH(DEP), .TAG_CHANNEL(1)) u_tag (
      .BUS_CLK(clk), .BUS_RST(rst), .FIFO_EMPTY(fifo_empty), .FIFO_DATA(fifo_data),
      .FIFO_READ(fifo_read_t), .TX_AFULL(afull), .TX_WR(tx_wr_t), .TX_DATA(tx_data_t),
      .FILL_LEVEL(fill_t));

   always #5 clk = ~clk;

   // First-word-fall-through source model
   always_comb begin
      for (int i = 0; i < CH; i++) begin
         fifo_empty[i]        = (head[i] == cnt[i]);
         fifo_data[32*i +: 32] = sd[i][head[i] % 256];
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < CH; i++)
         if (fifo_read[i]) head[i] <= head[i] + 1;
   end

   // Byte and grant logs, sampled after the tasks have settled their inputs
   always @(negedge clk) begin
      #2;
      if (tx_wr === 1'b1 && rx_n < 2048) begin
         rx_d[rx_n] = tx_data;
         rx_t[rx_n] = cyc;
         rx_n++;
      end
      if (|fifo_read && gn < 512) begin
         for (int i = 0; i < CH; i++) if (fifo_read[i]) gl[gn] = i;
         gn++;
      end
   end

   function automatic logic [31:0] fw(int ch, int k);
      return {4'(ch), 4'h5, 8'(k), 8'(8'hA5 ^ 8'(k)), 8'(ch*16 + k)};
   endfunction

   task automatic push(int ch, logic [31:0] w);
      sd[ch][cnt[ch] % 256] = w;
      cnt[ch]++;
   endtask

   task automatic clr_src();
      for (int i = 0; i < CH; i++) cnt[i] = head[i];
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; afull = 1'b0; clr_src();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      push(1, 32'hAAAA5555);
      #1;
      n_cmp++; if (fifo_read !== 4'b0000) begin n_err++; $display("FAIL rst_read got %b want 0000", fifo_read); end
      n_cmp++; if (tx_wr !== 1'b0) begin n_err++; $display("FAIL rst_txwr got %b want 0", tx_wr); end
      n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL rst_txdata got %h want 00", tx_data); end
      n_cmp++; if (fill !== 5'd0) begin n_err++; $display("FAIL rst_fill got %0d want 0", fill); end
      n_cmp++; if (fill_t !== 5'd0 || tx_wr_t !== 1'b0) begin n_err++; $display("FAIL rst_tag got fill %0d wr %b want 0 0", fill_t, tx_wr_t); end
      clr_src();
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++; if (fifo_read !== 4'b0000) begin n_err++; $display("FAIL rst_idle_read got %b want 0000", fifo_read); end
   endtask

   task automatic test_single();
      logic [31:0] w;
      w = 32'h44332211;
      @(negedge clk);
      push(2, w);
      #1;
      n_cmp++; if (fifo_read !== 4'b0100) begin n_err++; $display("FAIL single_grant got %b want 0100", fifo_read); end
      @(negedge clk); #1;
      n_cmp++; if (tx_wr !== 1'b0 || fill !== 5'd1) begin n_err++; $display("FAIL single_n1 got wr %b fill %0d want 0 1", tx_wr, fill); end
      for (int b = 0; b < 4; b++) begin
         @(negedge clk); #1;
         n_cmp++;
         if (tx_wr !== 1'b1 || tx_data !== w[8*b +: 8]) begin
            n_err++; $display("FAIL single_byte%0d got wr %b data %h want 1 %h", b, tx_wr, tx_data, w[8*b +: 8]);
         end
      end
      @(negedge clk); #1;
      n_cmp++; if (tx_wr !== 1'b0) begin n_err++; $display("FAIL single_done got wr %b want 0", tx_wr); end
   endtask

   task automatic test_fairness();
      int br, bg, per[CH];
      logic [31:0] w;
      do_reset();
      @(negedge clk);
      br = rx_n; bg = gn;
      for (int c = 0; c < CH; c++) for (int k = 0; k < 16; k++) push(c, fw(c, k));
      for (int t = 0; t < 400 && (rx_n - br) < 256; t++) @(negedge clk);
      #3;
      n_cmp++; if (rx_n - br != 256) begin n_err++; $display("FAIL fair_bytes got %0d want 256", rx_n - br); end
      per = '{default: 0};
      for (int j = 0; j < 64; j++) begin
         n_cmp++;
         if (gl[bg + j] != j % 4) begin n_err++; $display("FAIL fair_order%0d got %0d want %0d", j, gl[bg + j], j % 4); end
         if (gl[bg + j] >= 0 && gl[bg + j] < CH) per[gl[bg + j]]++;
      end
      for (int c = 0; c < CH; c++) begin
         n_cmp++; if (per[c] != 16) begin n_err++; $display("FAIL fair_share%0d got %0d want 16", c, per[c]); end
      end
      for (int j = 0; j < 64; j++) begin
         w = fw(j % 4, j / 4);
         n_cmp++;
         if ({rx_d[br+4*j+3], rx_d[br+4*j+2], rx_d[br+4*j+1], rx_d[br+4*j]} !== w) begin
            n_err++; $display("FAIL fair_word%0d got %h%h%h%h want %h", j, rx_d[br+4*j+3], rx_d[br+4*j+2], rx_d[br+4*j+1], rx_d[br+4*j], w);
         end
      end
      n_cmp++; if (rx_t[br+255] - rx_t[br] != 255) begin n_err++; $display("FAIL fair_gapless got span %0d want 255", rx_t[br+255] - rx_t[br]); end
   endtask

   task automatic test_backpressure();
      int br;
      do_reset();
      @(negedge clk);
      br = rx_n;
      push(0, 32'hDDCCBBAA);
      #1;
      n_cmp++; if (fifo_read !== 4'b0001) begin n_err++; $display("FAIL bp_grant got %b want 0001", fifo_read); end
      @(negedge clk);
      @(negedge clk); #1;
      n_cmp++; if (tx_wr !== 1'b1 || tx_data !== 8'hAA) begin n_err++; $display("FAIL bp_b0 got %b %h want 1 aa", tx_wr, tx_data); end
      @(negedge clk); #1;
      n_cmp++; if (tx_wr !== 1'b1 || tx_data !== 8'hBB) begin n_err++; $display("FAIL bp_b1 got %b %h want 1 bb", tx_wr, tx_data); end
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         afull = 1'b1;
         #1;
         n_cmp++;
         if (tx_wr !== 1'b0 || tx_data !== 8'hCC) begin n_err++; $display("FAIL bp_hold%0d got %b %h want 0 cc", t, tx_wr, tx_data); end
      end
      @(negedge clk);
      afull = 1'b0;
      #1;
      n_cmp++; if (tx_wr !== 1'b1 || tx_data !== 8'hCC) begin n_err++; $display("FAIL bp_b2 got %b %h want 1 cc", tx_wr, tx_data); end
      @(negedge clk); #1;
      n_cmp++; if (tx_wr !== 1'b1 || tx_data !== 8'hDD) begin n_err++; $display("FAIL bp_b3 got %b %h want 1 dd", tx_wr, tx_data); end
      @(negedge clk); #3;
      n_cmp++; if (rx_n - br != 4) begin n_err++; $display("FAIL bp_count got %0d want 4", rx_n - br); end
   endtask

   task automatic test_full();
      int br, bg;
      logic [31:0] w;
      do_reset();
      @(negedge clk);
      afull = 1'b1;
      br = rx_n; bg = gn;
      for (int c = 0; c < CH; c++) for (int k = 0; k < 8; k++) push(c, fw(c, k));
      repeat (30) @(negedge clk);
      #1;
      n_cmp++; if (fill !== 5'd16) begin n_err++; $display("FAIL full_level got %0d want 16", fill); end
      n_cmp++; if (fifo_read !== 4'b0000) begin n_err++; $display("FAIL full_noread got %b want 0000", fifo_read); end
      n_cmp++; if (gn - bg != 17) begin n_err++; $display("FAIL full_grants got %0d want 17", gn - bg); end
      @(negedge clk);
      afull = 1'b0;
      #1;
      w = fw(0, 0);
      n_cmp++; if (tx_wr !== 1'b1 || tx_data !== w[7:0]) begin n_err++; $display("FAIL full_resume got %b %h want 1 %h", tx_wr, tx_data, w[7:0]); end
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); #1;
      n_cmp++; if (fill !== 5'd16 || fifo_read !== 4'b0000) begin n_err++; $display("FAIL full_rd_no_grant got fill %0d read %b want 16 0000", fill, fifo_read); end
      @(negedge clk); #1;
      n_cmp++; if (fill !== 5'd15 || fifo_read !== 4'b0010) begin n_err++; $display("FAIL full_regrant got fill %0d read %b want 15 0010", fill, fifo_read); end
      for (int t = 0; t < 300 && (rx_n - br) < 128; t++) @(negedge clk);
      #3;
      n_cmp++; if (rx_n - br != 128) begin n_err++; $display("FAIL full_bytes got %0d want 128", rx_n - br); end
      for (int j = 0; j < 32; j++) begin
         w = fw(j % 4, j / 4);
         n_cmp++;
         if ({rx_d[br+4*j+3], rx_d[br+4*j+2], rx_d[br+4*j+1], rx_d[br+4*j]} !== w) begin
            n_err++; $display("FAIL full_word%0d got %h%h%h%h want %h", j, rx_d[br+4*j+3], rx_d[br+4*j+2], rx_d[br+4*j+1], rx_d[br+4*j], w);
         end
      end
   endtask

   task automatic test_tagging();
      logic [31:0] w;
      w = 32'hC000_0001;
      do_reset();
      @(negedge clk);
      push(3, 32'h0000_0001);
      #1;
      n_cmp++; if (fifo_read_t !== 4'b1000) begin n_err++; $display("FAIL tag_grant got %b want 1000", fifo_read_t); end
      @(negedge clk);
      for (int b = 0; b < 4; b++) begin
         @(negedge clk); #1;
         n_cmp++;
         if (tx_wr_t !== 1'b1 || tx_data_t !== w[8*b +: 8]) begin
            n_err++; $display("FAIL tag_byte%0d got %b %h want 1 %h", b, tx_wr_t, tx_data_t, w[8*b +: 8]);
         end
      end
      n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL untag_byte3 got %h want 00", tx_data); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      @(negedge clk);
      push(1, 32'h87654321);
      push(1, 32'h0BADF00D);
      #1;
      n_cmp++; if (fifo_read !== 4'b0010) begin n_err++; $display("FAIL rm_g0 got %b want 0010", fifo_read); end
      @(negedge clk); #1;
      n_cmp++; if (fifo_read !== 4'b0010) begin n_err++; $display("FAIL rm_g1 got %b want 0010", fifo_read); end
      @(negedge clk); #1;
      n_cmp++; if (tx_data !== 8'h21) begin n_err++; $display("FAIL rm_b0 got %h want 21", tx_data); end
      @(negedge clk);
      @(negedge clk); #1;
      n_cmp++; if (tx_wr !== 1'b1 || tx_data !== 8'h65 || fill !== 5'd1) begin n_err++; $display("FAIL rm_b2 got %b %h fill %0d want 1 65 1", tx_wr, tx_data, fill); end
      @(negedge clk);
      rst = 1'b1;
      push(1, 32'h13579BDF);
      push(3, 32'h2468ACE0);
      #1;
      n_cmp++; if (tx_wr !== 1'b0 || fill !== 5'd0 || fifo_read !== 4'b0000) begin n_err++; $display("FAIL rm_inrst got %b %0d %b want 0 0 0000", tx_wr, fill, fifo_read); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++; if (tx_wr !== 1'b0 || fill !== 5'd0) begin n_err++; $display("FAIL rm_after got wr %b fill %0d want 0 0", tx_wr, fill); end
      n_cmp++; if (fifo_read !== 4'b0010) begin n_err++; $display("FAIL rm_lowest got %b want 0010", fifo_read); end
      @(negedge clk); #1;
      n_cmp++; if (tx_wr !== 1'b0 || fifo_read !== 4'b1000) begin n_err++; $display("FAIL rm_n7 got %b %b want 0 1000", tx_wr, fifo_read); end
      @(negedge clk); #1;
      n_cmp++; if (tx_wr !== 1'b1 || tx_data !== 8'hDF) begin n_err++; $display("FAIL rm_newword got %b %h want 1 df", tx_wr, tx_data); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_full();
      test_tagging();
      test_reset_mid();
      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/readout_aggregator.md
READOUT_AGGREGATOR -- requirements
Module: readout_aggregator

Interface
REQ-001 Parameter CHANNELS, default 4, legal 2..8: number of 32-bit source channels.
REQ-002 Parameter DEPTH, default 1024, power of two 16..8192: internal word buffer depth.
REQ-003 Parameter TAG_CHANNEL, default 0: when 1, word bits [31:32-IDW] SHALL be overwritten with the source channel index, IDW = clog2(CHANNELS).
REQ-004 BUS_CLK  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 BUS_RST  in  1  synchronous, active-high reset.
REQ-006 FIFO_EMPTY  in  CHANNELS  per-channel source empty flag; bit i is channel i.
REQ-007 FIFO_DATA  in  32*CHANNELS  first-word-fall-through source data; channel i is at [32i+31:32i].
REQ-008 FIFO_READ  out  CHANNELS  one-hot pop strobe; the source word is captured on the same edge.
REQ-009 TX_AFULL  in  1  downstream almost-full; 1 means no byte may be written this cycle.
REQ-010 TX_WR  out  1  byte write strobe.
REQ-011 TX_DATA  out  8  byte data, valid when TX_WR=1.
REQ-012 FILL_LEVEL  out  clog2(DEPTH)+1  number of words held in the internal buffer, excluding the serializer register.

Function
REQ-013 Grant: in each cycle where the buffer is not full (FILL_LEVEL<DEPTH) and any FIFO_EMPTY bit is 0, exactly one FIFO_READ bit SHALL be 1; otherwise FIFO_READ SHALL be all 0.
REQ-014 Round-robin: the granted channel SHALL be the first non-empty channel searched from (last_grant+1) mod CHANNELS upward with wrap-around; last_grant resets to CHANNELS-1, so channel 0 has first priority.
REQ-015 FIFO_READ SHALL be combinational from FIFO_EMPTY, last_grant and fill state, and SHALL never assert for a channel whose FIFO_EMPTY bit is 1.
REQ-016 The granted word, tagged per REQ-003, SHALL be written to the buffer on the grant edge.
REQ-017 Full: when FILL_LEVEL=DEPTH, no grant SHALL occur, even if a buffer read happens in the same cycle; no word SHALL be lost or duplicated.
REQ-018 The serializer holds one 32-bit word plus a 2-bit byte index; when it is empty or its last byte is sent, it SHALL load the oldest buffered word on the next edge.
REQ-019 TX_WR SHALL equal serializer_valid AND NOT TX_AFULL; the byte index advances only when TX_WR=1.
REQ-020 Byte order SHALL be little-endian: bits [7:0] first, bits [31:24] last.
REQ-021 Latency: a word granted in cycle N into an empty buffer and empty serializer, with TX_AFULL=0, SHALL produce byte 0 with TX_WR=1 in cycle N+2; the four bytes SHALL follow on consecutive cycles.
REQ-022 Throughput: with TX_AFULL=0 and data continuously available, TX_WR SHALL stay high without gaps across word boundaries, because the reload overlaps the fourth byte.
REQ-023 TX_AFULL asserted mid-word SHALL freeze TX_DATA and the byte index; on deassertion, output SHALL resume at the same byte.
REQ-024 Simultaneous buffer write and read SHALL leave FILL_LEVEL unchanged; pointers SHALL wrap modulo DEPTH.

Reset
REQ-025 While BUS_RST=1: FIFO_READ=0, TX_WR=0, TX_DATA=0x00 and FILL_LEVEL=0; buffer pointers, byte index, serializer_valid and last_grant are reinitialised.
REQ-026 Reset mid-word SHALL discard the buffer and any partially sent word; no TX_WR SHALL be issued in the cycle after reset deasserts.

Verification
REQ-027 Single word: CHANNELS=4, channel 2 supplies 0x44332211 in cycle N, TX_AFULL=0 -> TX_WR in N+2..N+5 with TX_DATA 0x11, 0x22, 0x33, 0x44.
REQ-028 Fairness: all 4 channels continuously non-empty -> grant order 0,1,2,3,0,1,...; each channel receives 25% of grants over 64 words.
REQ-029 Backpressure: TX_AFULL=1 for 10 cycles after byte 1 of word 0xDDCCBBAA -> output resumes with 0xCC, then 0xDD, and no byte is repeated or dropped.
REQ-030 Full: DEPTH=16, TX_AFULL held at 1, channels continuously non-empty -> FILL_LEVEL saturates at 16 and FIFO_READ stays 0 until TX_AFULL drops; all words are then delivered in grant order.
REQ-031 Tagging: TAG_CHANNEL=1, CHANNELS=4, channel 3 word 0x0000_0001 -> serialized bytes 0x01, 0x00, 0x00, 0xC0.
REQ-032 Reset mid-stream: BUS_RST pulsed for 1 cycle after byte 2 -> FILL_LEVEL=0 and TX_WR=0 in the next cycle; the next grant goes to the lowest non-empty channel.
